// File: rtl/systolic_drain_is.sv
// systolic_drain_is: output-side reader for the input-stationary systolic array.
// Deskews bottom-row MAC words, reduces each element and queues rows in a FIFO.
// Ports: clk, rst_n (async, active-low), reg_clear (sync flush),
//   in_valid/mac_in (skewed column words, column c lags column 0 by c cycles),
//   out_valid/out_ready/out_data (row stream), fifo_count, full,
//   stall_req (almost-full), overflow (sticky drop flag).
// Option macro DRAIN_SATURATE_EN: signed saturation instead of truncation,
//   and adds the sticky sat_flag output.
module systolic_drain_is #(
   parameter int COLS      = 4,
   parameter int WIDTH_MAC = 48,
   parameter int WIDTH_OUT = 32,
   parameter int DEPTH     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         reg_clear,
   input  logic                         in_valid,
   input  logic [COLS*WIDTH_MAC-1:0]    mac_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [COLS*WIDTH_OUT-1:0]    out_data,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         full,
   output logic                         stall_req,
   output logic                         overflow
`ifdef DRAIN_SATURATE_EN
   ,
   output logic                         sat_flag
`endif
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RW = COLS*WIDTH_OUT;

   // valid delay line: row_valid lags in_valid by COLS-1 cycles
   logic [COLS-2:0] vld_q, vld_d;
   logic            row_valid;

   always_comb begin
      vld_d    = '0;
      vld_d[0] = in_valid;
      for (int i = 1; i < COLS-1; i++) vld_d[i] = vld_q[i-1];
      if (reg_clear) vld_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   assign row_valid = vld_q[COLS-2];

   // column c is held back COLS-1-c cycles so all columns line up
   logic [WIDTH_MAC-1:0] aligned [COLS];

   for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == COLS-1) begin : g_pass
         assign aligned[c] = mac_in[c*WIDTH_MAC +: WIDTH_MAC];
      end else begin : g_dly
         localparam int N = COLS-1-c;
         logic [WIDTH_MAC-1:0] sh_q [N];
         logic [WIDTH_MAC-1:0] sh_d [N];

         always_comb begin
            sh_d[0] = mac_in[c*WIDTH_MAC +: WIDTH_MAC];
            for (int k = 1; k < N; k++) sh_d[k] = sh_q[k-1];
            if (reg_clear)
               for (int k = 0; k < N; k++) sh_d[k] = '0;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < N; k++) sh_q[k] <= '0;
            end else begin
               sh_q <= sh_d;
            end
         end

         assign aligned[c] = sh_q[N-1];
      end
   end

   // element reduction
   logic [RW-1:0] row_red;
   logic          sat_any;

`ifdef DRAIN_SATURATE_EN
   always_comb begin
      row_red = '0;
      sat_any = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         // in range when all bits above the output sign bit match it
         if ((&aligned[c][WIDTH_MAC-1:WIDTH_OUT-1]) ||
             !(|aligned[c][WIDTH_MAC-1:WIDTH_OUT-1])) begin
            row_red[c*WIDTH_OUT +: WIDTH_OUT] = aligned[c][WIDTH_OUT-1:0];
         end else begin
            sat_any = 1'b1;
            if (aligned[c][WIDTH_MAC-1])
               row_red[c*WIDTH_OUT +: WIDTH_OUT] = {1'b1, {(WIDTH_OUT-1){1'b0}}};
            else
               row_red[c*WIDTH_OUT +: WIDTH_OUT] = {1'b0, {(WIDTH_OUT-1){1'b1}}};
         end
      end
   end
`else
   logic unused_hi;

   always_comb begin
      row_red   = '0;
      sat_any   = 1'b0;
      unused_hi = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         row_red[c*WIDTH_OUT +: WIDTH_OUT] = aligned[c][WIDTH_OUT-1:0];
         unused_hi = unused_hi ^ (^aligned[c]);
      end
      unused_hi = unused_hi ^ sat_any;
   end
`endif

   // row FIFO
   logic [RW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          sat_q, sat_d;
   logic          pop, full_w, accept;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      pop      = (count_q != '0) && out_ready;
      full_w   = (count_q == CW'(DEPTH));
      // a pop in the same cycle frees the slot a full FIFO needs
      accept   = row_valid && (!full_w || pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      sat_d    = sat_q;
      if (reg_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         sat_d    = 1'b0;
      end else begin
         if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
         if (accept && !pop)      count_d = count_q + 1'b1;
         else if (!accept && pop) count_d = count_q - 1'b1;
         if (row_valid && !accept) ovf_d = 1'b1;
         if (accept && sat_any)    sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
      end
   end

   // storage needs no reset: out_data is gated by out_valid
   always_ff @(posedge clk) begin
      if (accept && !reg_clear) mem_q[wr_ptr_q] <= row_red;
   end

   assign out_valid  = (count_q != '0);
   assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_count = count_q;
   assign full       = full_w;
   assign stall_req  = (count_q >= CW'(DEPTH-COLS+1));
   assign overflow   = ovf_q;

`ifdef DRAIN_SATURATE_EN
   assign sat_flag = sat_q;
`else
   logic unused_sat;
   assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_systolic_drain_is.sv
// tb_systolic_drain_is: directed bench for systolic_drain_is
// (COLS=4, WIDTH_MAC=48, WIDTH_OUT=32, DEPTH=8).
module tb_systolic_drain_is;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         reg_clear;
   logic         in_valid;
   logic [191:0] mac_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   fifo_count;
   logic         full;
   logic         stall_req;
   logic         overflow;
`ifdef DRAIN_SATURATE_EN
   logic         sat_flag;
`endif

   int total = 0;
   int bad   = 0;

   logic [47:0] fut [4][4];

   always #5 clk = ~clk;

   systolic_drain_is #(
      .COLS(4), .WIDTH_MAC(48), .WIDTH_OUT(32), .DEPTH(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .reg_clear(reg_clear),
      .in_valid(in_valid),
      .mac_in(mac_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .fifo_count(fifo_count),
      .full(full),
      .stall_req(stall_req),
      .overflow(overflow)
`ifdef DRAIN_SATURATE_EN
      ,
      .sat_flag(sat_flag)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: column c of a new row goes out c cycles after column 0
   task automatic cyc(input logic v, input logic [47:0] m0, m1, m2, m3);
      if (v) begin
         fut[0][0] = m0;
         fut[1][1] = m1;
         fut[2][2] = m2;
         fut[3][3] = m3;
      end
      in_valid = v;
      for (int c = 0; c < 4; c++) mac_in[c*48 +: 48] = fut[0][c];
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 4; c++) fut[d][c] = fut[d+1][c];
      for (int c = 0; c < 4; c++) fut[3][c] = '0;
   endtask

   task automatic idle();
      cyc(1'b0, '0, '0, '0, '0);
   endtask

   task automatic row_in(input int r, input int base);
      cyc(1'b1, 48'(base + 16*r), 48'(base + 16*r + 1),
          48'(base + 16*r + 2), 48'(base + 16*r + 3));
   endtask

   function automatic logic [127:0] row_exp(input int r, input int base);
      return {32'(base + 16*r + 3), 32'(base + 16*r + 2),
              32'(base + 16*r + 1), 32'(base + 16*r)};
   endfunction

   initial begin
      for (int d = 0; d < 4; d++)
         for (int c = 0; c < 4; c++) fut[d][c] = '0;
      rst_n     = 1'b0;
      reg_clear = 1'b0;
      in_valid  = 1'b0;
      mac_in    = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", out_data, 128'(0));
      chk("rst_count", 128'(fifo_count), 128'(0));
      chk("rst_full", 128'(full), 128'(0));
      chk("rst_stall", 128'(stall_req), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
      rst_n = 1'b1;
      idle();

      // single row with 4-cycle latency
      out_ready = 1'b1;
      cyc(1'b1, 48'd1, 48'd2, 48'd3, 48'd4);
      chk("single_c1_valid", 128'(out_valid), 128'(0));
      idle();
      idle();
      chk("single_c3_valid", 128'(out_valid), 128'(0));
      idle();
      chk("single_c4_valid", 128'(out_valid), 128'(1));
      chk("single_c4_data", out_data,
          {32'd4, 32'd3, 32'd2, 32'd1});
      idle();
      chk("single_c5_valid", 128'(out_valid), 128'(0));
      chk("single_c5_count", 128'(fifo_count), 128'(0));

      // fill past capacity with no consumer
      out_ready = 1'b0;
      for (int r = 0; r < 7; r++) row_in(r, 0);
      chk("fill_count4", 128'(fifo_count), 128'(4));
      chk("fill_stall_off", 128'(stall_req), 128'(0));
      row_in(7, 0);
      chk("fill_count5", 128'(fifo_count), 128'(5));
      chk("fill_stall_on", 128'(stall_req), 128'(1));
      row_in(8, 0);
      idle();
      idle();
      chk("fill_count8", 128'(fifo_count), 128'(8));
      chk("fill_full", 128'(full), 128'(1));
      chk("fill_no_ovf_yet", 128'(overflow), 128'(0));
      idle();
      chk("fill_ovf", 128'(overflow), 128'(1));
      chk("fill_count_hold", 128'(fifo_count), 128'(8));
      chk("fill_head_stable", out_data, row_exp(0, 0));
      out_ready = 1'b1;
      for (int r = 0; r < 8; r++) begin
         chk($sformatf("drain_valid_%0d", r), 128'(out_valid), 128'(1));
         chk($sformatf("drain_data_%0d", r), out_data, row_exp(r, 0));
         idle();
      end
      chk("drain_empty", 128'(out_valid), 128'(0));
      chk("drain_ovf_sticky", 128'(overflow), 128'(1));
      reg_clear = 1'b1;
      idle();
      reg_clear = 1'b0;
      chk("clear_ovf", 128'(overflow), 128'(0));

      // push and pop together while full
      out_ready = 1'b0;
      for (int r = 0; r < 8; r++) row_in(r, 256);
      cyc(1'b1, 48'hAA, 48'hAB, 48'hAC, 48'hAD);
      idle();
      idle();
      chk("pp_full_before", 128'(fifo_count), 128'(8));
      out_ready = 1'b1;
      idle();
      chk("pp_count", 128'(fifo_count), 128'(8));
      chk("pp_no_ovf", 128'(overflow), 128'(0));
      for (int r = 1; r < 8; r++) begin
         chk($sformatf("pp_data_%0d", r), out_data, row_exp(r, 256));
         idle();
      end
      chk("pp_last_row", out_data,
          {32'hAD, 32'hAC, 32'hAB, 32'hAA});
      idle();
      chk("pp_empty", 128'(fifo_count), 128'(0));

      // flush with rows in flight
      out_ready = 1'b0;
      for (int r = 0; r < 5; r++) row_in(r, 512);
      idle();
      chk("clr_count3", 128'(fifo_count), 128'(3));
      reg_clear = 1'b1;
      idle();
      reg_clear = 1'b0;
      chk("clr_count0", 128'(fifo_count), 128'(0));
      chk("clr_valid0", 128'(out_valid), 128'(0));
      chk("clr_ovf0", 128'(overflow), 128'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle();
         chk($sformatf("clr_no_ghost_%0d", i), 128'(out_valid), 128'(0));
      end

      // element reduction
      cyc(1'b1, 48'h0000_8000_0000, 48'hFFFF_7FFF_FFFF,
          48'hFFFF_FFFF_FFFF, 48'd5);
      idle();
      idle();
      idle();
      chk("red_valid", 128'(out_valid), 128'(1));
`ifdef DRAIN_SATURATE_EN
      chk("red_data", out_data,
          {32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF});
`else
      chk("red_data", out_data,
          {32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000});
`endif
      idle();
`ifdef DRAIN_SATURATE_EN
      chk("red_sat_flag", 128'(sat_flag), 128'(1));
`endif
      chk("red_empty", 128'(fifo_count), 128'(0));

      // asynchronous reset with rows stored and in flight
      out_ready = 1'b0;
      for (int r = 0; r < 6; r++) row_in(r, 768);
      idle();
      chk("ar_count4", 128'(fifo_count), 128'(4));
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 128'(out_valid), 128'(0));
      chk("ar_data", out_data, 128'(0));
      chk("ar_count", 128'(fifo_count), 128'(0));
      chk("ar_stall", 128'(stall_req), 128'(0));
      chk("ar_full", 128'(full), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle();
         chk($sformatf("ar_no_row_%0d", i), 128'(out_valid), 128'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
